// File: rtl/sbp_pkg.sv
// Shared types and constants for the scalable pipelined lookup tree:
// update command record, pipeline bus item and the prefix-masking helper.
package sbp_pkg;

    localparam int STAGE_ID_BITS = 6;
    localparam int LOCATION_BITS = 11;
    localparam int RESULT_BITS   = 24;
    localparam int ADDR_BITS     = 32;
    localparam int LEN_BITS      = 6;

    localparam logic [STAGE_ID_BITS-1:0] BUBBLE_STAGE_ID = '0;
    localparam logic [STAGE_ID_BITS-1:0] ROOT_STAGE_ID   = STAGE_ID_BITS'(1);

    typedef struct packed {
        logic [ADDR_BITS-1:0]     prefix;
        logic [LEN_BITS-1:0]      len;
        logic [STAGE_ID_BITS-1:0] stage_id;
        logic [LOCATION_BITS-1:0] location;
        logic [RESULT_BITS-1:0]   result;
    } sbp_upd_cmd_t;

    typedef struct packed {
        logic                     update;
        logic [ADDR_BITS-1:0]     ip_addr;
        logic [LEN_BITS-1:0]      bit_pos;
        logic [STAGE_ID_BITS-1:0] stage_id;
        logic [LOCATION_BITS-1:0] location;
        logic [RESULT_BITS-1:0]   result;
    } sbp_bus_t;

    // Keeps only the top len bits; a zero length yields an all-zero prefix.
    function automatic logic [ADDR_BITS-1:0] mask_prefix(
        input logic [ADDR_BITS-1:0] prefix,
        input logic [LEN_BITS-1:0]  len
    );
        logic [ADDR_BITS-1:0] keep;
        if (len == '0) begin
            keep = '0;
        end else begin
            keep = {ADDR_BITS{1'b1}} << (LEN_BITS'(ADDR_BITS) - len);
        end
        return prefix & keep;
    endfunction

endpackage

// File: rtl/sbp_sync_fifo.sv
// Generic single-clock FIFO with first-word-fall-through read data,
// occupancy count and full/empty flags. DEPTH must be a power of two.
module sbp_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CNT_BITS = $clog2(DEPTH + 1),
    localparam int PTR_BITS = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic [WIDTH-1:0]    wdata,
    input  logic                pop,
    output logic [WIDTH-1:0]    rdata,
    output logic [CNT_BITS-1:0] count,
    output logic                full,
    output logic                empty
);

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] rd_ptr;
    logic                do_push;
    logic                do_pop;

    assign full    = (count == CNT_BITS'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/sbp_update_injector.sv
// Head-of-pipeline injector: merges lookups and buffered table updates onto
// the first stage's bus with a bounded update burst, and tracks in-flight updates.
module sbp_update_injector
    import sbp_pkg::*;
#(
    parameter int NUM_STAGES     = 8,
    parameter int UPD_FIFO_DEPTH = 4,
    parameter int MAX_UPD_BURST  = 4,
    localparam int PEND_BITS  = $clog2(UPD_FIFO_DEPTH + 1),
    localparam int BURST_BITS = $clog2(MAX_UPD_BURST + 1),
    localparam int TRACK_BITS = 2 * NUM_STAGES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     lkp_valid_i,
    output logic                     lkp_ready_o,
    input  logic [ADDR_BITS-1:0]     lkp_ip_addr_i,
    input  logic                     upd_valid_i,
    output logic                     upd_ready_o,
    input  logic [ADDR_BITS-1:0]     upd_prefix_i,
    input  logic [LEN_BITS-1:0]      upd_prefix_len_i,
    input  logic [STAGE_ID_BITS-1:0] upd_stage_id_i,
    input  logic [LOCATION_BITS-1:0] upd_location_i,
    input  logic [RESULT_BITS-1:0]   upd_result_i,
    output logic                     update_o,
    output logic [ADDR_BITS-1:0]     ip_addr_o,
    output logic [LEN_BITS-1:0]      bit_pos_o,
    output logic [STAGE_ID_BITS-1:0] stage_id_o,
    output logic [LOCATION_BITS-1:0] location_o,
    output logic [RESULT_BITS-1:0]   result_o,
    output logic                     upd_err_o,
    output logic                     upd_done_o,
    output logic [PEND_BITS-1:0]     upd_pending_o,
    output logic                     upd_idle_o
);

    sbp_upd_cmd_t          new_cmd;
    sbp_upd_cmd_t          fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [PEND_BITS-1:0]  fifo_count;
    logic [BURST_BITS-1:0] burst_cnt;
    logic [TRACK_BITS-1:0] in_flight;
    sbp_bus_t              bus_q;
    logic                  upd_err_q;
    logic                  cmd_ok;
    logic                  upd_fire;
    logic                  lkp_fire;
    logic                  push_cmd;
    logic                  pop_cmd;

    assign upd_ready_o = !fifo_full;
    assign lkp_ready_o = fifo_empty || (burst_cnt == BURST_BITS'(MAX_UPD_BURST));
    assign upd_fire    = upd_valid_i && upd_ready_o;
    assign lkp_fire    = lkp_valid_i && lkp_ready_o;

    assign cmd_ok = (upd_prefix_len_i <= LEN_BITS'(ADDR_BITS))
                 && (upd_stage_id_i != BUBBLE_STAGE_ID)
                 && (upd_stage_id_i <= STAGE_ID_BITS'(NUM_STAGES));

    assign push_cmd = upd_fire && cmd_ok;
    assign pop_cmd  = !lkp_fire && !fifo_empty;

    assign new_cmd.prefix   = mask_prefix(upd_prefix_i, upd_prefix_len_i);
    assign new_cmd.len      = upd_prefix_len_i;
    assign new_cmd.stage_id = upd_stage_id_i;
    assign new_cmd.location = upd_location_i;
    assign new_cmd.result   = upd_result_i;

    sbp_sync_fifo #(
        .WIDTH($bits(sbp_upd_cmd_t)),
        .DEPTH(UPD_FIFO_DEPTH)
    ) u_upd_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push_cmd),
        .wdata(new_cmd),
        .pop  (pop_cmd),
        .rdata(fifo_head),
        .count(fifo_count),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    // A granted lookup always wins the slot; the burst counter is what makes
    // lkp_ready rise after MAX_UPD_BURST back-to-back updates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_q     <= '0;
            upd_err_q <= 1'b0;
            burst_cnt <= '0;
            in_flight <= '0;
        end else begin
            upd_err_q <= upd_fire && !cmd_ok;
            in_flight <= {in_flight[TRACK_BITS-2:0], bus_q.update};
            if (lkp_fire) begin
                bus_q          <= '0;
                bus_q.ip_addr  <= lkp_ip_addr_i;
                bus_q.stage_id <= ROOT_STAGE_ID;
                burst_cnt      <= '0;
            end else if (!fifo_empty) begin
                bus_q.update   <= 1'b1;
                bus_q.ip_addr  <= fifo_head.prefix;
                bus_q.bit_pos  <= fifo_head.len;
                bus_q.stage_id <= fifo_head.stage_id;
                bus_q.location <= fifo_head.location;
                bus_q.result   <= fifo_head.result;
                if (burst_cnt != BURST_BITS'(MAX_UPD_BURST)) begin
                    burst_cnt <= burst_cnt + 1'b1;
                end
            end else begin
                bus_q     <= '0;
                burst_cnt <= '0;
            end
        end
    end

    assign update_o      = bus_q.update;
    assign ip_addr_o     = bus_q.ip_addr;
    assign bit_pos_o     = bus_q.bit_pos;
    assign stage_id_o    = bus_q.stage_id;
    assign location_o    = bus_q.location;
    assign result_o      = bus_q.result;
    assign upd_err_o     = upd_err_q;
    assign upd_done_o    = in_flight[TRACK_BITS-1];
    assign upd_pending_o = fifo_count;
    assign upd_idle_o    = fifo_empty && (in_flight == '0);

endmodule

// File: tb/tb_sbp_update_injector.sv
// Scoreboard bench for sbp_update_injector: a transaction-level model predicts
// every cycle's outputs into a queue that a negedge monitor drains and compares.
module tb_sbp_update_injector;
    import sbp_pkg::*;

    localparam int NS    = 8;
    localparam int DEPTH = 4;
    localparam int MAXB  = 4;

    typedef struct {
        sbp_bus_t   bus;
        logic       err;
        logic       done;
        logic       idle;
        logic       lrdy;
        logic       urdy;
        logic [2:0] pending;
    } exp_t;

    logic clk;
    logic rst;
    logic lkp_valid;
    logic lkp_ready;
    logic [31:0] lkp_ip_addr;
    logic upd_valid;
    logic upd_ready;
    logic [31:0] upd_prefix;
    logic [5:0]  upd_prefix_len;
    logic [5:0]  upd_stage_id;
    logic [10:0] upd_location;
    logic [23:0] upd_result;
    logic update;
    logic [31:0] ip_addr;
    logic [5:0]  bit_pos;
    logic [5:0]  stage_id;
    logic [10:0] location;
    logic [23:0] result;
    logic upd_err;
    logic upd_done;
    logic [2:0] upd_pending;
    logic upd_idle;

    sbp_update_injector #(
        .NUM_STAGES(NS),
        .UPD_FIFO_DEPTH(DEPTH),
        .MAX_UPD_BURST(MAXB)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .lkp_valid_i     (lkp_valid),
        .lkp_ready_o     (lkp_ready),
        .lkp_ip_addr_i   (lkp_ip_addr),
        .upd_valid_i     (upd_valid),
        .upd_ready_o     (upd_ready),
        .upd_prefix_i    (upd_prefix),
        .upd_prefix_len_i(upd_prefix_len),
        .upd_stage_id_i  (upd_stage_id),
        .upd_location_i  (upd_location),
        .upd_result_i    (upd_result),
        .update_o        (update),
        .ip_addr_o       (ip_addr),
        .bit_pos_o       (bit_pos),
        .stage_id_o      (stage_id),
        .location_o      (location),
        .result_o        (result),
        .upd_err_o       (upd_err),
        .upd_done_o      (upd_done),
        .upd_pending_o   (upd_pending),
        .upd_idle_o      (upd_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    exp_t exp_q[$];

    // Reference model state: queued commands, burst length, bus cycles of issued updates.
    sbp_upd_cmd_t mq[$];
    int       burst;
    int       now;
    int       hist[$];
    sbp_bus_t m_bus;
    bit       m_err;
    bit       last_upd_acc;

    function automatic void check(string name, logic [95:0] act, logic [95:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %h, required %h", name, now, act, req);
        end
    endfunction

    function automatic logic [31:0] ref_mask(logic [31:0] p, int len);
        logic [31:0] r;
        r = p;
        for (int i = 0; i < 32; i++) begin
            if (i < 32 - len) r[i] = 1'b0;
        end
        return r;
    endfunction

    function automatic sbp_upd_cmd_t rand_cmd(bit allow_bad);
        sbp_upd_cmd_t c;
        c.prefix   = $urandom;
        c.len      = 6'(allow_bad ? $urandom_range(0, 36) : $urandom_range(0, 32));
        c.stage_id = 6'(allow_bad ? $urandom_range(0, 10) : $urandom_range(1, NS));
        c.location = 11'($urandom);
        c.result   = 24'($urandom);
        return c;
    endfunction

    function automatic void model_reset();
        mq.delete();
        hist.delete();
        burst        = 0;
        m_bus        = '0;
        m_err        = 1'b0;
        last_upd_acc = 1'b0;
    endfunction

    function automatic void push_expect();
        exp_t e;
        while (hist.size() > 0 && hist[0] < now - 2 * NS) void'(hist.pop_front());
        e.bus     = m_bus;
        e.err     = m_err;
        e.pending = 3'(mq.size());
        e.urdy    = mq.size() < DEPTH;
        e.lrdy    = (mq.size() == 0) || (burst == MAXB);
        e.done    = 1'b0;
        e.idle    = mq.size() == 0;
        foreach (hist[i]) begin
            if (hist[i] == now - 2 * NS) e.done = 1'b1;
            if (hist[i] >= now - 2 * NS && hist[i] <= now - 1) e.idle = 1'b0;
        end
        exp_q.push_back(e);
    endfunction

    task automatic applyStimulus(input logic lv, input logic [31:0] la,
                                 input logic uv, input sbp_upd_cmd_t c);
        lkp_valid      = lv;
        lkp_ip_addr    = la;
        upd_valid      = uv;
        upd_prefix     = c.prefix;
        upd_prefix_len = c.len;
        upd_stage_id   = c.stage_id;
        upd_location   = c.location;
        upd_result     = c.result;
    endtask

    // Advance the model across one rising edge using the inputs the DUT just sampled.
    task automatic next_cycle();
        bit lr, ur, lf, uf, ok, was_empty;
        sbp_upd_cmd_t c;
        @(posedge clk);
        #1;
        lr = (mq.size() == 0) || (burst == MAXB);
        ur = mq.size() < DEPTH;
        lf = lkp_valid && lr;
        uf = upd_valid && ur;
        ok = (upd_prefix_len <= 32) && (upd_stage_id >= 1) && (upd_stage_id <= NS);
        was_empty = mq.size() == 0;
        m_bus = '0;
        if (lf) begin
            m_bus.ip_addr  = lkp_ip_addr;
            m_bus.stage_id = 6'd1;
            burst = 0;
        end else if (!was_empty) begin
            c = mq.pop_front();
            m_bus.update   = 1'b1;
            m_bus.ip_addr  = c.prefix;
            m_bus.bit_pos  = c.len;
            m_bus.stage_id = c.stage_id;
            m_bus.location = c.location;
            m_bus.result   = c.result;
            burst = (burst < MAXB) ? burst + 1 : MAXB;
        end else begin
            burst = 0;
        end
        if (uf && ok) begin
            c.prefix   = ref_mask(upd_prefix, int'(upd_prefix_len));
            c.len      = upd_prefix_len;
            c.stage_id = upd_stage_id;
            c.location = upd_location;
            c.result   = upd_result;
            mq.push_back(c);
        end
        m_err        = uf && !ok;
        last_upd_acc = uf;
        now++;
        if (m_bus.update) hist.push_back(now);
        push_expect();
    endtask

    task automatic check_reset_state(string tag);
        check({tag, ".bus"}, 96'({update, ip_addr, bit_pos, stage_id, location, result}), 96'(0));
        check({tag, ".err_done"}, 96'({upd_err, upd_done}), 96'(0));
        check({tag, ".pending"}, 96'(upd_pending), 96'(0));
        check({tag, ".idle_rdy"}, 96'({upd_idle, lkp_ready, upd_ready}), 96'(3'b111));
    endtask

    task automatic checkOutput(input exp_t e);
        sbp_bus_t act;
        act = {update, ip_addr, bit_pos, stage_id, location, result};
        check("bus", 96'(act), 96'(e.bus));
        check("upd_err", 96'(upd_err), 96'(e.err));
        check("upd_done", 96'(upd_done), 96'(e.done));
        check("upd_pending", 96'(upd_pending), 96'(e.pending));
        check("upd_idle", 96'(upd_idle), 96'(e.idle));
        check("lkp_ready", 96'(lkp_ready), 96'(e.lrdy));
        check("upd_ready", 96'(upd_ready), 96'(e.urdy));
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL scoreboard: no expectation for cycle %0d", now);
            end else begin
                checkOutput(exp_q.pop_front());
            end
        end
    end

    task automatic reset_mid_run();
        @(posedge clk);
        #2;
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, '0);
        #1;
        check_reset_state("async_reset");
        model_reset();
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_expect();
    endtask

    sbp_upd_cmd_t cmd;
    int sent;

    initial begin
        rst = 1'b1;
        now = 0;
        model_reset();
        applyStimulus(1'b0, 32'h0, 1'b0, '0);
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b0;
        push_expect();

        $display("[TB] single lookup");
        next_cycle();
        applyStimulus(1'b1, 32'hC0A80001, 1'b0, '0);
        repeat (3) begin
            next_cycle();
            applyStimulus(1'b0, 32'h0, 1'b0, '0);
        end

        $display("[TB] single update and completion");
        cmd = '{prefix: 32'hC0A8FFFF, len: 6'd16, stage_id: 6'd3, location: 11'd5, result: 24'hABCDEF};
        next_cycle();
        applyStimulus(1'b0, 32'h0, 1'b1, cmd);
        repeat (22) begin
            next_cycle();
            applyStimulus(1'b0, 32'h0, 1'b0, '0);
        end

        $display("[TB] invalid commands");
        cmd = '{prefix: 32'h12345678, len: 6'd33, stage_id: 6'd2, location: 11'd1, result: 24'h1};
        next_cycle();
        applyStimulus(1'b0, 32'h0, 1'b1, cmd);
        cmd.len = 6'd8;
        cmd.stage_id = 6'd0;
        next_cycle();
        applyStimulus(1'b0, 32'h0, 1'b1, cmd);
        cmd.stage_id = 6'd9;
        next_cycle();
        applyStimulus(1'b0, 32'h0, 1'b1, cmd);
        repeat (3) begin
            next_cycle();
            applyStimulus(1'b0, 32'h0, 1'b0, '0);
        end

        $display("[TB] continuous lookups and updates");
        sent = 0;
        cmd = rand_cmd(1'b0);
        applyStimulus(1'b1, $urandom, 1'b1, cmd);
        for (int k = 0; k < 150 && sent < 10; k++) begin
            next_cycle();
            if (last_upd_acc) begin
                sent++;
                cmd = rand_cmd(1'b0);
            end
            applyStimulus(1'b1, $urandom, sent < 10, cmd);
        end
        repeat (20) begin
            next_cycle();
            applyStimulus(1'b1, $urandom, 1'b0, '0);
        end

        $display("[TB] back-to-back updates, no lookups");
        sent = 0;
        cmd = rand_cmd(1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, cmd);
        for (int k = 0; k < 50 && sent < 5; k++) begin
            next_cycle();
            if (last_upd_acc) begin
                sent++;
                cmd = rand_cmd(1'b0);
            end
            applyStimulus(1'b0, 32'h0, sent < 5, cmd);
        end

        $display("[TB] reset with updates queued and in flight");
        repeat (3) begin
            next_cycle();
            applyStimulus(1'b0, 32'h0, 1'b1, rand_cmd(1'b0));
        end
        reset_mid_run();
        repeat (20) begin
            next_cycle();
            applyStimulus(1'b0, 32'h0, 1'b0, '0);
        end

        $display("[TB] random traffic");
        for (int k = 0; k < 400; k++) begin
            next_cycle();
            applyStimulus(1'($urandom_range(0, 1)), $urandom,
                          ($urandom_range(0, 3) != 0), rand_cmd(1'b1));
        end
        repeat (24) begin
            next_cycle();
            applyStimulus(1'b0, 32'h0, 1'b0, '0);
        end

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
